prog_sequencer: RTL
===================

Name: prog_sequencer

Overview:
- Instruction fetch/sequencer for the 1-bit processor; it is the issuing end of the control unit's instruction interface.
- Fetches 12-bit program words from program memory over a req/ack handshake.
- Drives opcode 0x0–0xB to the control unit as a single-cycle issue, with NOOP (4'h0) at all other times.
- Executes flow-control opcodes 0xC–0xF locally; the control unit never sees them.

Parameters:
- AW, 8, program address width; also the operand width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- run  in  1  run enable, sampled in IDLE
- mem_req  out  1  program memory read request
- mem_addr  out  AW  read address (= pc)
- mem_rdata  in  4+AW  word: [AW+3:AW] opcode, [AW-1:0] operand
- mem_ack  in  1  rdata valid this cycle
- rr  in  1  result register bit, for SKZ
- instr  out  4  opcode to control unit; 4'h0 unless instr_valid
- oper  out  AW  operand (I/O select for the data bit); 0 unless instr_valid
- instr_valid  out  1  issue strobe
- halted  out  1  sequencer stopped by HALT
- pc  out  AW  current program counter (debug)

Behaviour:
- Reset (rst, synchronous, active-high; clock clk) wins over everything, including a mid-fetch transaction. Reset values:
  - pc=RESET_PC; state=IDLE.
  - mem_req=0, instr=0, oper=0, instr_valid=0, halted=0, skip=0.
  - Any mem_ack arriving after reset is ignored.
- States: IDLE, FETCH, ISSUE, HALT.
- IDLE: if run=1, go to FETCH next cycle.
- FETCH:
  - mem_req=1 and mem_addr=pc, held stable until mem_ack.
  - On the mem_ack edge, capture mem_rdata, deassert mem_req, go to ISSUE.
  - mem_ack while mem_req=0 is ignored.
- ISSUE (one cycle) on the captured word, opcode op:
  - skip=1: no effect, instr_valid=0, clear skip, pc+1. Applies to every opcode, including C–F.
  - op 0x0–0xB: instr=op, oper=operand, instr_valid=1 for exactly this cycle, pc+1.
  - op 0xC JMP: pc=operand, instr_valid=0.
  - op 0xD RTN: see Optional Feature; in the base build it behaves as NOOP (pc+1, no issue).
  - op 0xE SKZ: if rr=0 set skip, pc+1. rr is sampled in the ISSUE cycle.
  - op 0xF HALT: go to HALT, pc unchanged.
- After ISSUE: go to FETCH if run=1, else IDLE.
- Throughput with zero-wait memory (ack in the first req cycle): one instruction per 2 cycles.
- pc arithmetic is modulo 2^AW; 2^AW−1 wraps to 0.
- HALT: halted=1, mem_req=0, instr=0. Only rst exits this state.
- run going low during FETCH does not abort the transaction; the fetched word still issues, then the sequencer goes to IDLE.

Optional Feature:
- Macro: PROG_SEQ_RET_STACK_EN.
- Defined: 4-entry return stack.
  - JMP pushes pc+1 before loading the target.
  - RTN pops into pc.
  - Push when full overwrites the oldest entry (circular).
  - RTN on empty behaves as NOOP (pc+1).
  - A skipped JMP/RTN does not touch the stack.
  - Reset empties the stack.
- Undefined: no stack logic; JMP is a plain jump; RTN is NOOP.

Decomposition:
- Package prog_seq_pkg:
  - Opcode constants OP_NOOP..OP_HALT (0x0–0xF).
  - State enum.
  - WORD_W = 4+AW helper.
- Sub-module ret_stack: depth-4 circular LIFO with push/pop/empty. Instantiated only under PROG_SEQ_RET_STACK_EN.

Test Plan:
- Reset then run=1, memory {0:0x1_05, 1:0x8_02, 2:0xF_00}, zero-wait ack → issues (1,05) then (8,02) two cycles apart; halted=1; mem_req stays 0 afterwards; instr=0 outside issue cycles.
- JMP: word 0=0xC_10, word 0x10=0x3_01 → no issue for the JMP; next mem_addr=0x10; issue (3,01).
- SKZ with rr=0 at 0x00, 0x1_07 at 0x01, 0x5_07 at 0x02 → 0x01 fetched but not issued; 0x02 issues. Repeat with rr=1 → both issue.
- Wait states: ack delayed 3 cycles → mem_req and mem_addr stable throughout; exactly one issue per word. Assert rst during a wait → mem_req=0 next cycle, pc=0, the late ack is ignored.
- Wrap: RESET_PC=0xFF, word 0xFF=0x2_00 → issue, then mem_addr=0x00.
- With PROG_SEQ_RET_STACK_EN: JMP 0x20 from 0x05, RTN at 0x20 → next fetch at 0x06. Five nested JMPs then five RTNs → the fifth RTN behaves as NOOP (first return address lost).

Source files
------------

// File: rtl/prog_seq_pkg.sv
// prog_seq_pkg: opcodes, sequencer states and word-width helper shared by the sequencer slice.
package prog_seq_pkg;
  typedef enum logic [3:0] {
    OP_NOOP, OP_LD, OP_LDC, OP_AND, OP_ANDC, OP_OR, OP_ORC, OP_XNOR,
    OP_STO, OP_STOC, OP_IEN, OP_OEN, OP_JMP, OP_RTN, OP_SKZ, OP_HALT
  } op_t;
  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, HALT} state_t;
  function automatic int word_w(input int aw);
    return 4 + aw;
  endfunction
endpackage

// File: rtl/prog_sequencer_if.sv
// prog_sequencer_if: program-memory fetch bus plus the issue port towards the control unit.
interface prog_sequencer_if #(parameter int AW = 8);
  logic mem_req;
  logic mem_ack;
  logic instr_valid;
  logic [AW-1:0] mem_addr;
  logic [AW-1:0] oper;
  logic [prog_seq_pkg::word_w(AW)-1:0] mem_rdata;
  logic [3:0] instr;
  modport master(output mem_req, mem_addr, instr, oper, instr_valid, input mem_rdata, mem_ack);
  modport slave(input mem_req, mem_addr, instr, oper, instr_valid, output mem_rdata, mem_ack);
endinterface

// File: rtl/ret_stack.sv
// ret_stack: depth-4 circular LIFO of return addresses; a push when full overwrites the oldest entry.
module ret_stack #(parameter int W = 8) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         empty
);
  logic [W-1:0] mem [4];
  logic [1:0] ptr;
  logic [2:0] cnt;
  assign top = mem[ptr - 2'd1];
  assign empty = cnt == 3'd0;
  always_ff @(posedge clk) begin
    if (push) mem[ptr] <= din;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      cnt <= '0;
    end else if (push) begin
      ptr <= ptr + 2'd1;
      cnt <= cnt == 3'd4 ? cnt : cnt + 3'd1;
    end else if (pop && !empty) begin
      ptr <= ptr - 2'd1;
      cnt <= cnt - 3'd1;
    end
  end
endmodule

// File: rtl/prog_sequencer.sv
// prog_sequencer: fetches program words, issues opcodes 0x0-0xB and executes JMP/RTN/SKZ/HALT locally.
// Optional return stack for JMP/RTN under PROG_SEQ_RET_STACK_EN.
module prog_sequencer import prog_seq_pkg::*; #(
  parameter int AW = 8,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              rr,
  output logic              halted,
  output logic [AW-1:0]     pc,
  prog_sequencer_if.master  bus
);
  state_t state;
  logic [word_w(AW)-1:0] word;
  logic skip;
  op_t op;
  logic [AW-1:0] operand, pc_inc, pc_nxt, rtn_pc;
  logic [3:0] rd_op;
  logic rd_iss;
  assign op = op_t'(word[AW+3:AW]);
  assign operand = word[AW-1:0];
  assign pc_inc = pc + 1'b1;
  assign bus.mem_addr = pc;
  assign rd_op = bus.mem_rdata[AW+3:AW];
  assign rd_iss = !skip && rd_op < 4'(OP_JMP);
`ifdef PROG_SEQ_RET_STACK_EN
  logic do_push, do_pop, stk_empty;
  logic [AW-1:0] stk_top;
  assign do_push = state == ISSUE && !skip && op == OP_JMP;
  assign do_pop = state == ISSUE && !skip && op == OP_RTN;
  ret_stack #(.W(AW)) u_stk (
    .clk(clk), .rst(rst), .push(do_push), .pop(do_pop),
    .din(pc_inc), .top(stk_top), .empty(stk_empty)
  );
  assign rtn_pc = stk_empty ? pc_inc : stk_top;
`else
  assign rtn_pc = pc_inc;
`endif
  always_comb
    pc_nxt = skip ? pc_inc :
             op == OP_JMP ? operand :
             op == OP_RTN ? rtn_pc :
             op == OP_HALT ? pc : pc_inc;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc <= RESET_PC;
      word <= '0;
      skip <= 1'b0;
      halted <= 1'b0;
      bus.mem_req <= 1'b0;
      bus.instr <= OP_NOOP;
      bus.oper <= '0;
      bus.instr_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (run) begin
          state <= FETCH;
          bus.mem_req <= 1'b1;
        end
        FETCH: if (bus.mem_ack) begin
          word <= bus.mem_rdata;
          bus.mem_req <= 1'b0;
          bus.instr <= rd_iss ? rd_op : OP_NOOP;
          bus.oper <= rd_iss ? bus.mem_rdata[AW-1:0] : '0;
          bus.instr_valid <= rd_iss;
          state <= ISSUE;
        end
        ISSUE: begin
          bus.instr <= OP_NOOP;
          bus.oper <= '0;
          bus.instr_valid <= 1'b0;
          pc <= pc_nxt;
          skip <= !skip && op == OP_SKZ && !rr;
          // HALT only takes effect when it was not itself skipped
          if (!skip && op == OP_HALT) begin
            state <= HALT;
            halted <= 1'b1;
          end else begin
            state <= run ? FETCH : IDLE;
            bus.mem_req <= run;
          end
        end
        HALT: state <= HALT;
      endcase
    end
  end
endmodule
